// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - pipeline, ALU and data SRAM signals of the execute stage
interface ex_stage_if;
  logic         id_to_ex_valid;
  logic         ex_allowin;
  logic [157:0] id_to_ex_bus;
  logic [11:0]  ex_alu_op;
  logic [31:0]  ex_alu_src1;
  logic [31:0]  ex_alu_src2;
  logic [31:0]  ex_alu_result;
  logic         mem_allowin;
  logic         ex_to_mem_valid;
  logic [75:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_flush;
  logic         mem_to_ex_excep;
  logic [38:0]  ex_rf_zip;

  modport slave (
    input  id_to_ex_valid, id_to_ex_bus, ex_alu_result, mem_allowin,
           ex_flush, mem_to_ex_excep,
    output ex_allowin, ex_alu_op, ex_alu_src1, ex_alu_src2, ex_to_mem_valid,
           ex_to_mem_bus, data_sram_en, data_sram_we, data_sram_addr,
           data_sram_wdata, ex_rf_zip
  );

  modport master (
    output id_to_ex_valid, id_to_ex_bus, ex_alu_result, mem_allowin,
           ex_flush, mem_to_ex_excep,
    input  ex_allowin, ex_alu_op, ex_alu_src1, ex_alu_src2, ex_to_mem_valid,
           ex_to_mem_bus, data_sram_en, data_sram_we, data_sram_addr,
           data_sram_wdata, ex_rf_zip
  );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: pipeline register, 32-cycle restoring divider,
// load/store alignment check and data SRAM request generation.
module ex_stage (
  input  logic      clk,
  input  logic      reset,
  ex_stage_if.slave ex_if
);
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

  logic         ex_valid_q, ex_valid_d;
  logic [157:0] ex_bus_q, ex_bus_d;
  div_state_e   state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [31:0]  rem_q, rem_d;
  logic [31:0]  quo_q, quo_d;

  logic [11:0] alu_op;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] pc, src1, src2, st_data;
  logic [4:0]  ld_type;
  logic [2:0]  st_type;
  logic [3:0]  div_op;

  assign {alu_op, rf_we, rf_waddr, pc, src1, src2, st_data, ld_type, st_type, div_op} = ex_bus_q;

  logic        ex_allowin, ex_to_mem_valid, ready_go;
  logic        is_div, div_signed, q_neg, r_neg;
  logic [31:0] dvd_abs, dvs_abs;
  logic [31:0] trial_lo, trial_diff;
  logic        trial_ge;
  logic [31:0] quo_fix, rem_fix, div_quo, div_rem, result;

  assign is_div     = |div_op;
  assign div_signed = div_op[3] | div_op[2];
  assign dvd_abs    = (div_signed && src1[31]) ? -src1 : src1;
  assign dvs_abs    = (div_signed && src2[31]) ? -src2 : src2;
  assign q_neg      = div_signed & (src1[31] ^ src2[31]);
  assign r_neg      = div_signed & src1[31];

  // Partial remainder is {rem_q, next dividend bit}; its top bit alone proves it exceeds the divisor.
  assign trial_lo   = {rem_q[30:0], quo_q[31]};
  assign trial_ge   = rem_q[31] | (trial_lo >= dvs_abs);
  assign trial_diff = trial_lo - dvs_abs;

  assign quo_fix = q_neg ? -quo_q : quo_q;
  assign rem_fix = r_neg ? -rem_q : rem_q;
  assign div_quo = (src2 == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
  assign div_rem = (src2 == 32'd0) ? src1 : rem_fix;

  always_comb begin
    result = ex_if.ex_alu_result;
    if (div_op[3] || div_op[1]) begin
      result = div_quo;
    end else if (div_op[2] || div_op[0]) begin
      result = div_rem;
    end
  end

  assign ready_go        = ~is_div | (state_q == DIV_DONE);
  assign ex_allowin      = ~ex_valid_q | (ready_go & ex_if.mem_allowin) | ex_if.ex_flush;
  assign ex_to_mem_valid = ex_valid_q & ready_go & ~ex_if.ex_flush;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_bus_d   = ex_bus_q;
    if (ex_allowin) begin
      ex_valid_d = ex_if.id_to_ex_valid;
    end
    if (ex_allowin && ex_if.id_to_ex_valid) begin
      ex_bus_d = ex_if.id_to_ex_bus;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    if (ex_if.ex_flush) begin
      state_d = DIV_IDLE;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (ex_valid_q && is_div) begin
            state_d = DIV_CALC;
            cnt_d   = 5'd0;
            rem_d   = 32'd0;
            quo_d   = dvd_abs;
          end
        end
        DIV_CALC: begin
          // quo_q shifts the dividend out at the top and the quotient in at the bottom.
          rem_d = trial_ge ? trial_diff : trial_lo;
          quo_d = {quo_q[30:0], trial_ge};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (ex_to_mem_valid && ex_if.mem_allowin) begin
            state_d = DIV_IDLE;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_bus_q   <= '0;
      state_q    <= DIV_IDLE;
      cnt_q      <= 5'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_bus_q   <= ex_bus_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
    end
  end

  logic [31:0] addr;
  logic        excp_ale, is_mem, is_store, sram_en;
  logic [3:0]  byte_mask;
  logic [31:0] wdata;

  assign addr     = ex_if.ex_alu_result;
  assign is_store = |st_type;
  assign is_mem   = (|ld_type) | is_store;
  assign excp_ale = ((ld_type[0] | st_type[0]) & (|addr[1:0]))
                  | ((ld_type[2] | ld_type[1] | st_type[1]) & addr[0]);
  assign sram_en  = ex_valid_q & is_mem & ~excp_ale & ~ex_if.ex_flush
                  & ~ex_if.mem_to_ex_excep & ex_if.mem_allowin;

  always_comb begin
    byte_mask = 4'b0000;
    wdata     = st_data;
    if (st_type[2]) begin
      byte_mask = 4'b0001 << addr[1:0];
      wdata     = {4{st_data[7:0]}};
    end else if (st_type[1]) begin
      byte_mask = addr[1] ? 4'b1100 : 4'b0011;
      wdata     = {2{st_data[15:0]}};
    end else if (st_type[0]) begin
      byte_mask = 4'b1111;
    end
  end

  assign ex_if.ex_allowin      = ex_allowin;
  assign ex_if.ex_to_mem_valid = ex_to_mem_valid;
  assign ex_if.ex_alu_op       = alu_op;
  assign ex_if.ex_alu_src1     = src1;
  assign ex_if.ex_alu_src2     = src2;
  assign ex_if.ex_to_mem_bus   = {rf_we, rf_waddr, pc, result, ld_type, excp_ale};
  assign ex_if.data_sram_en    = sram_en;
  assign ex_if.data_sram_we    = (sram_en && is_store) ? byte_mask : 4'b0000;
  assign ex_if.data_sram_addr  = addr;
  assign ex_if.data_sram_wdata = wdata;
  assign ex_if.ex_rf_zip       = {ex_valid_q & ((|ld_type) | (is_div & (state_q != DIV_DONE))),
                                  rf_we & ex_valid_q, rf_waddr, result};
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  localparam logic [4:0]  LD_W   = 5'b00001;
  localparam logic [4:0]  LD_H   = 5'b00100;
  localparam logic [2:0]  ST_B   = 3'b100;
  localparam logic [2:0]  ST_H   = 3'b010;
  localparam logic [2:0]  ST_W   = 3'b001;
  localparam logic [3:0]  DIV_W  = 4'b1000;
  localparam logic [3:0]  MOD_W  = 4'b0100;
  localparam logic [3:0]  DIV_WU = 4'b0010;
  localparam logic [3:0]  MOD_WU = 4'b0001;
  localparam logic [31:0] PC     = 32'h1C00_0100;

  ex_stage_if ex_if();
  ex_stage dut (.clk(clk), .reset(reset), .ex_if(ex_if.slave));

  always #5 clk = ~clk;
  assign ex_if.ex_alu_result = ex_if.ex_alu_src1 + ex_if.ex_alu_src2;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } dv_t;

  dv_t dv_tab [11] = '{
    '{DIV_W,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD},
    '{MOD_W,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF},
    '{DIV_WU, 32'd7,         32'd0,          32'hFFFF_FFFF},
    '{MOD_WU, 32'd7,         32'd0,          32'd7},
    '{MOD_W,  32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9},
    '{DIV_W,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000},
    '{MOD_W,  32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000},
    '{DIV_WU, 32'hFFFF_FFFF, 32'd3,          32'h5555_5555},
    '{MOD_WU, 32'd100,       32'd7,          32'd2},
    '{DIV_W,  32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD},
    '{MOD_W,  32'd7,         32'hFFFF_FFFE,  32'd1}
  };

  function automatic logic [157:0] mk(input logic [11:0] op, input logic [4:0] wa,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] sd, input logic [4:0] ld,
                                      input logic [2:0] st, input logic [3:0] dv);
    return {op, 1'b1, wa, PC, s1, s2, sd, ld, st, dv};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [157:0] bus);
    ex_if.id_to_ex_bus   = bus;
    ex_if.id_to_ex_valid = 1'b1;
    step();
    ex_if.id_to_ex_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (ex_if.ex_to_mem_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset;
    ex_if.id_to_ex_valid  = 1'b0;
    ex_if.id_to_ex_bus    = '0;
    ex_if.mem_allowin     = 1'b1;
    ex_if.ex_flush        = 1'b0;
    ex_if.mem_to_ex_excep = 1'b0;
    reset = 1'b1;
    step();
    step();
    checks++; if (ex_if.ex_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin: got %b want 1", ex_if.ex_allowin); end
    checks++; if (ex_if.ex_to_mem_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", ex_if.ex_to_mem_valid); end
    checks++; if (ex_if.data_sram_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b want 0", ex_if.data_sram_en); end
    checks++; if (ex_if.data_sram_we !== 4'b0) begin failures++; $display("FAIL reset_we: got %b want 0000", ex_if.data_sram_we); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_add;
    accept(mk(12'h001, 5'd4, 32'd2, 32'd3, 32'd0, 5'd0, 3'd0, 4'd0));
    checks++; if (ex_if.ex_to_mem_valid !== 1'b1) begin failures++; $display("FAIL add_valid: got %b want 1", ex_if.ex_to_mem_valid); end
    checks++; if (ex_if.ex_to_mem_bus[37:6] !== 32'h5) begin failures++; $display("FAIL add_result: got %h want 00000005", ex_if.ex_to_mem_bus[37:6]); end
    checks++; if (ex_if.data_sram_en !== 1'b0) begin failures++; $display("FAIL add_en: got %b want 0", ex_if.data_sram_en); end
    checks++; if (ex_if.ex_alu_op !== 12'h001) begin failures++; $display("FAIL add_aluop: got %h want 001", ex_if.ex_alu_op); end
    checks++; if (ex_if.ex_rf_zip !== {1'b0, 1'b1, 5'd4, 32'h5}) begin failures++; $display("FAIL add_zip: got %h", ex_if.ex_rf_zip); end
    step();
    checks++; if (ex_if.ex_to_mem_valid !== 1'b0) begin failures++; $display("FAIL add_drain: got %b want 0", ex_if.ex_to_mem_valid); end
  endtask

  task automatic test_divide;
    for (int i = 0; i < 11; i++) begin
      int n;
      accept(mk(12'h000, 5'd7, dv_tab[i].a, dv_tab[i].b, 32'd0, 5'd0, 3'd0, dv_tab[i].op));
      checks++; if (ex_if.ex_rf_zip[38] !== 1'b1) begin failures++; $display("FAIL div%0d_blocking: got %b want 1", i, ex_if.ex_rf_zip[38]); end
      wait_done(n);
      checks++; if (n != 34) begin failures++; $display("FAIL div%0d_latency: got %0d want 34", i, n); end
      checks++; if (ex_if.ex_to_mem_bus[37:6] !== dv_tab[i].exp) begin failures++; $display("FAIL div%0d_result: got %h want %h", i, ex_if.ex_to_mem_bus[37:6], dv_tab[i].exp); end
      checks++; if (ex_if.ex_rf_zip[38] !== 1'b0) begin failures++; $display("FAIL div%0d_done_blocking: got %b want 0", i, ex_if.ex_rf_zip[38]); end
      step();
    end
  endtask

  task automatic test_store;
    accept(mk(12'h001, 5'd0, 32'h1000, 32'd2, 32'h0000_ABCD, 5'd0, ST_H, 4'd0));
    checks++; if (ex_if.data_sram_en !== 1'b1) begin failures++; $display("FAIL sth_en: got %b want 1", ex_if.data_sram_en); end
    checks++; if (ex_if.data_sram_we !== 4'b1100) begin failures++; $display("FAIL sth_we: got %b want 1100", ex_if.data_sram_we); end
    checks++; if (ex_if.data_sram_wdata !== 32'hABCD_ABCD) begin failures++; $display("FAIL sth_wdata: got %h want abcdabcd", ex_if.data_sram_wdata); end
    checks++; if (ex_if.data_sram_addr !== 32'h1002) begin failures++; $display("FAIL sth_addr: got %h want 00001002", ex_if.data_sram_addr); end
    step();
    accept(mk(12'h001, 5'd0, 32'h1000, 32'd3, 32'h1234_5678, 5'd0, ST_B, 4'd0));
    checks++; if (ex_if.data_sram_we !== 4'b1000) begin failures++; $display("FAIL stb_we: got %b want 1000", ex_if.data_sram_we); end
    checks++; if (ex_if.data_sram_wdata !== 32'h7878_7878) begin failures++; $display("FAIL stb_wdata: got %h want 78787878", ex_if.data_sram_wdata); end
    step();
    accept(mk(12'h001, 5'd0, 32'h1000, 32'd1, 32'h1111_2222, 5'd0, ST_W, 4'd0));
    checks++; if (ex_if.data_sram_en !== 1'b0) begin failures++; $display("FAIL stw_mis_en: got %b want 0", ex_if.data_sram_en); end
    checks++; if (ex_if.ex_to_mem_bus[0] !== 1'b1) begin failures++; $display("FAIL stw_mis_ale: got %b want 1", ex_if.ex_to_mem_bus[0]); end
    checks++; if (ex_if.data_sram_we !== 4'b0000) begin failures++; $display("FAIL stw_mis_we: got %b want 0000", ex_if.data_sram_we); end
    step();
    ex_if.mem_to_ex_excep = 1'b1;
    accept(mk(12'h001, 5'd0, 32'h1000, 32'd4, 32'h1111_2222, 5'd0, ST_W, 4'd0));
    checks++; if (ex_if.data_sram_en !== 1'b0) begin failures++; $display("FAIL stw_excep_en: got %b want 0", ex_if.data_sram_en); end
    ex_if.mem_to_ex_excep = 1'b0;
    #1;
    checks++; if (ex_if.data_sram_we !== 4'b1111) begin failures++; $display("FAIL stw_we: got %b want 1111", ex_if.data_sram_we); end
    checks++; if (ex_if.data_sram_wdata !== 32'h1111_2222) begin failures++; $display("FAIL stw_wdata: got %h want 11112222", ex_if.data_sram_wdata); end
    step();
    accept(mk(12'h001, 5'd1, 32'h1000, 32'd3, 32'd0, LD_H, 3'd0, 4'd0));
    checks++; if (ex_if.data_sram_en !== 1'b0) begin failures++; $display("FAIL ldh_mis_en: got %b want 0", ex_if.data_sram_en); end
    checks++; if (ex_if.ex_to_mem_bus[0] !== 1'b1) begin failures++; $display("FAIL ldh_mis_ale: got %b want 1", ex_if.ex_to_mem_bus[0]); end
    step();
  endtask

  task automatic test_stall;
    logic [75:0] exp_bus;
    int en_cnt;
    exp_bus = {1'b1, 5'd3, PC, 32'h2004, LD_W, 1'b0};
    en_cnt  = 0;
    ex_if.mem_allowin = 1'b0;
    accept(mk(12'h001, 5'd3, 32'h2000, 32'd4, 32'd0, LD_W, 3'd0, 4'd0));
    for (int c = 0; c < 3; c++) begin
      if (ex_if.data_sram_en === 1'b1) en_cnt++;
      checks++; if (ex_if.ex_to_mem_bus !== exp_bus) begin failures++; $display("FAIL stall_bus%0d: got %h want %h", c, ex_if.ex_to_mem_bus, exp_bus); end
      checks++; if (ex_if.ex_allowin !== 1'b0) begin failures++; $display("FAIL stall_allowin%0d: got %b want 0", c, ex_if.ex_allowin); end
      step();
    end
    checks++; if (ex_if.ex_rf_zip[38] !== 1'b1) begin failures++; $display("FAIL stall_blocking: got %b want 1", ex_if.ex_rf_zip[38]); end
    ex_if.mem_allowin = 1'b1;
    #1;
    if (ex_if.data_sram_en === 1'b1) en_cnt++;
    checks++; if (ex_if.data_sram_we !== 4'b0000) begin failures++; $display("FAIL stall_we: got %b want 0000", ex_if.data_sram_we); end
    step();
    if (ex_if.data_sram_en === 1'b1) en_cnt++;
    checks++; if (en_cnt != 1) begin failures++; $display("FAIL stall_en_pulses: got %0d want 1", en_cnt); end
    checks++; if (ex_if.ex_to_mem_valid !== 1'b0) begin failures++; $display("FAIL stall_drain: got %b want 0", ex_if.ex_to_mem_valid); end
  endtask

  task automatic test_flush;
    int n;
    int early;
    early = 0;
    accept(mk(12'h000, 5'd7, 32'd100, 32'd7, 32'd0, 5'd0, 3'd0, DIV_W));
    for (n = 1; n < 12; n++) begin
      if (ex_if.ex_to_mem_valid !== 1'b0) early++;
      step();
    end
    ex_if.ex_flush = 1'b1;
    #1;
    checks++; if (early != 0 || ex_if.ex_to_mem_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: early=%0d got %b want 0", early, ex_if.ex_to_mem_valid); end
    checks++; if (ex_if.ex_allowin !== 1'b1) begin failures++; $display("FAIL flush_allowin: got %b want 1", ex_if.ex_allowin); end
    step();
    ex_if.ex_flush = 1'b0;
    #1;
    checks++; if (ex_if.ex_to_mem_valid !== 1'b0) begin failures++; $display("FAIL flush_killed: got %b want 0", ex_if.ex_to_mem_valid); end
    checks++; if (ex_if.ex_allowin !== 1'b1) begin failures++; $display("FAIL flush_next_allowin: got %b want 1", ex_if.ex_allowin); end
    accept(mk(12'h000, 5'd7, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd0, 3'd0, DIV_W));
    wait_done(n);
    checks++; if (n != 34) begin failures++; $display("FAIL flush_next_latency: got %0d want 34", n); end
    checks++; if (ex_if.ex_to_mem_bus[37:6] !== 32'hFFFF_FFFD) begin failures++; $display("FAIL flush_next_result: got %h want fffffffd", ex_if.ex_to_mem_bus[37:6]); end
    step();
  endtask

  task automatic test_back_to_back;
    int n;
    accept(mk(12'h000, 5'd7, 32'd100, 32'd7, 32'd0, 5'd0, 3'd0, DIV_WU));
    ex_if.id_to_ex_bus   = mk(12'h001, 5'd5, 32'd1, 32'd2, 32'd0, 5'd0, 3'd0, 4'd0);
    ex_if.id_to_ex_valid = 1'b1;
    repeat (4) step();
    checks++; if (ex_if.ex_allowin !== 1'b0) begin failures++; $display("FAIL b2b_calc_allowin: got %b want 0", ex_if.ex_allowin); end
    wait_done(n);
    n = n + 4;
    checks++; if (n != 34) begin failures++; $display("FAIL b2b_latency: got %0d want 34", n); end
    checks++; if (ex_if.ex_to_mem_bus[37:6] !== 32'd14) begin failures++; $display("FAIL b2b_div_result: got %h want 0000000e", ex_if.ex_to_mem_bus[37:6]); end
    checks++; if (ex_if.ex_allowin !== 1'b1) begin failures++; $display("FAIL b2b_done_allowin: got %b want 1", ex_if.ex_allowin); end
    step();
    checks++; if (ex_if.ex_to_mem_valid !== 1'b1 || ex_if.ex_to_mem_bus[37:6] !== 32'd3) begin failures++; $display("FAIL b2b_add1: valid %b result %h want 1/00000003", ex_if.ex_to_mem_valid, ex_if.ex_to_mem_bus[37:6]); end
    ex_if.id_to_ex_bus = mk(12'h001, 5'd6, 32'd10, 32'd20, 32'd0, 5'd0, 3'd0, 4'd0);
    step();
    ex_if.id_to_ex_valid = 1'b0;
    checks++; if (ex_if.ex_to_mem_valid !== 1'b1 || ex_if.ex_to_mem_bus[37:6] !== 32'd30) begin failures++; $display("FAIL b2b_add2: valid %b result %h want 1/0000001e", ex_if.ex_to_mem_valid, ex_if.ex_to_mem_bus[37:6]); end
    step();
    checks++; if (ex_if.ex_to_mem_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %b want 0", ex_if.ex_to_mem_valid); end
  endtask

  task automatic test_reset_mid_div;
    int spurious;
    spurious = 0;
    accept(mk(12'h000, 5'd7, 32'd100, 32'd7, 32'd0, 5'd0, 3'd0, DIV_W));
    repeat (15) step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ex_if.ex_allowin !== 1'b1) begin failures++; $display("FAIL rst_mid_allowin: got %b want 1", ex_if.ex_allowin); end
    checks++; if (ex_if.ex_to_mem_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b want 0", ex_if.ex_to_mem_valid); end
    checks++; if (ex_if.data_sram_en !== 1'b0 || ex_if.data_sram_we !== 4'b0) begin failures++; $display("FAIL rst_mid_sram: en %b we %b want 0/0000", ex_if.data_sram_en, ex_if.data_sram_we); end
    step();
    reset = 1'b0;
    repeat (40) begin
      if (ex_if.ex_to_mem_valid !== 1'b0) spurious++;
      step();
    end
    checks++; if (spurious != 0) begin failures++; $display("FAIL rst_mid_abandon: got %0d valid cycles want 0", spurious); end
    accept(mk(12'h001, 5'd2, 32'd4, 32'd5, 32'd0, 5'd0, 3'd0, 4'd0));
    checks++; if (ex_if.ex_to_mem_valid !== 1'b1 || ex_if.ex_to_mem_bus[37:6] !== 32'd9) begin failures++; $display("FAIL rst_mid_add: valid %b result %h want 1/00000009", ex_if.ex_to_mem_valid, ex_if.ex_to_mem_bus[37:6]); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_divide();
    test_store();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports as follows (clock and reset first):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- id_to_ex_valid  in  1  ID holds a valid instruction
- ex_allowin  out  1  EX accepts a new instruction this cycle
- id_to_ex_bus  in  158  MSB first: alu_op[11:0], rf_we, rf_waddr[4:0], pc[31:0], src1[31:0], src2[31:0], st_data[31:0], ld_type[4:0] {b,bu,h,hu,w}, st_type[2:0] {b,h,w}, div_op[3:0] {div.w,mod.w,div.wu,mod.wu}
- ex_alu_op / ex_alu_src1 / ex_alu_src2  out  12/32/32  latched operands to the external ALU
- ex_alu_result  in  32  combinational ALU result
- mem_allowin  in  1  MEM accepts
- ex_to_mem_valid  out  1  instruction handed to MEM
- ex_to_mem_bus  out  76  MSB first: rf_we, rf_waddr[4:0], pc[31:0], result[31:0], ld_type[4:0], excp_ale
- data_sram_en / data_sram_we / data_sram_addr / data_sram_wdata  out  1/4/32/32  synchronous data SRAM request
- ex_flush  in  1  kill the instruction held in EX
- mem_to_ex_excep  in  1  MEM holds an exception or ertn; suppress memory side effects
- ex_rf_zip  out  39  forwarding: {blocking, rf_we&valid, rf_waddr, result}

Function
REQ-002 SHALL latch id_to_ex_bus into the EX register only when id_to_ex_valid & ex_allowin.
REQ-003 SHALL update ex_valid to id_to_ex_valid on every cycle where ex_allowin=1.
REQ-004 ex_allowin SHALL = ~ex_valid | (ready_go & mem_allowin) | ex_flush.
REQ-005 ex_to_mem_valid SHALL = ex_valid & ready_go & ~ex_flush.
REQ-006 ready_go SHALL be 1 for non-divide instructions; for divide instructions, only in divider state DONE.
REQ-007 Divider FSM SHALL be IDLE -> CALC -> DONE -> IDLE. IDLE->CALC on the first cycle ex_valid=1 with div_op!=0. CALC runs a 5-bit counter 0..31, one restoring quotient bit per cycle. CALC->DONE after count 31. DONE->IDLE when ex_to_mem_valid & mem_allowin.
REQ-008 A divide SHALL therefore occupy EX for exactly 34 cycles when MEM never stalls: 1 IDLE, 32 CALC, 1 DONE.
REQ-009 Signed ops SHALL divide the magnitudes. Quotient is negated when the operand signs differ; remainder takes the sign of src1. Results are 32-bit two's complement, and 0x80000000/-1 SHALL give quotient 0x80000000, remainder 0.
REQ-010 When src2=0, ALL div ops SHALL give quotient 0xFFFFFFFF and remainder src1.
REQ-011 result SHALL be the quotient for div.w/div.wu, the remainder for mod.w/mod.wu, and ex_alu_result otherwise.
REQ-012 excp_ale SHALL be 1 for (ld.w|st.w) with addr[1:0]!=0 and for (ld.h|ld.hu|st.h) with addr[0]!=0, where addr=ex_alu_result.
REQ-013 data_sram_en SHALL = ex_valid & (any ld|st) & ~excp_ale & ~ex_flush & ~mem_to_ex_excep & mem_allowin. This issues exactly one request, in the hand-off cycle.
REQ-014 data_sram_we SHALL be 0 unless data_sram_en & store. Byte enables: st.b 4'b0001<<addr[1:0]; st.h 4'b0011 or 4'b1100 selected by addr[1]; st.w 4'b1111.
REQ-015 data_sram_wdata SHALL be the byte replicated x4 for st.b, the half replicated x2 for st.h, and st_data for st.w. data_sram_addr SHALL = ex_alu_result.
REQ-016 ex_flush SHALL force the divider to IDLE on the next edge, and kill data_sram_en in the same cycle.
REQ-017 ex_rf_zip.blocking SHALL = ex_valid & (ld_type!=0 | (div_op!=0 & state!=DONE)).
REQ-018 A new instruction SHALL NOT be latched while a divide is in CALC (follows from REQ-004).

Reset
REQ-019 While reset=1, and immediately and asynchronously: ex_valid=0, FSM=IDLE, counter=0, EX register=0.
REQ-020 Outputs under reset SHALL be ex_allowin=1, ex_to_mem_valid=0, data_sram_en=0, data_sram_we=0.
REQ-021 Reset asserted mid-divide SHALL abandon the divide, with no result emitted.

Verification
REQ-022 add.w, ALU returns 0x00000005, mem_allowin=1 -> ex_to_mem_valid high on the cycle after acceptance, result=0x5, data_sram_en=0.
REQ-023 div.w src1=-7, src2=2 -> ready after 34 cycles, result 0xFFFFFFFD; mod.w on the same operands -> 0xFFFFFFFF; div.wu 7/0 -> 0xFFFFFFFF.
REQ-024 st.h addr 0x1002, st_data 0x0000ABCD -> data_sram_en=1, we=4'b1100, wdata=0xABCDABCD; st.w addr 0x1001 -> en=0, excp_ale=1.
REQ-025 ex_flush pulsed at CALC count 10 -> ex_to_mem_valid stays 0, FSM returns to IDLE, the next instruction is accepted the following cycle.
REQ-026 mem_allowin=0 for 3 cycles with a ld.w held -> data_sram_en=0 while stalled, exactly one en pulse when mem_allowin rises, bus stable throughout the stall.
REQ-027 reset pulse mid-divide -> all REQ-020 values immediately; a subsequent add.w completes normally.
